// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port control slice.
package rf_ctrl_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector (up to eight requesters).
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_picker.sv
// Round-robin picker: first eligible requester at or above the pointer,
// wrapping to the lowest eligible index below it.
module rr_picker #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_eligible,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic            o_valid
);

    logic [NREQ-1:0] w_grant_hi;
    logic [NREQ-1:0] w_grant_lo;
    logic            w_hi_found;
    logic            w_lo_found;

    // Search the upper segment [ptr, NREQ) and the wrapped segment [0, ptr) separately.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_grant_hi = '0;
        w_grant_lo = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_hi_found && i_eligible[i] && (i >= int'(i_ptr))) begin
                w_grant_hi[i] = 1'b1;
                w_hi_found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_lo_found && i_eligible[i] && (i < int'(i_ptr))) begin
                w_grant_lo[i] = 1'b1;
                w_lo_found    = 1'b1;
            end
        end
        o_grant = w_hi_found ? w_grant_hi : w_grant_lo;
        o_valid = w_hi_found | w_lo_found;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among NREQ requesters (round robin,
// registered ack) and runs a hardware sweep that writes zero to every register.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int AW           = RF_AW,
    parameter int DW           = RF_DW,
    parameter int ZERO_PROTECT = 0
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NREQ-1:0]    Req,
    input  logic [NREQ*AW-1:0] ReqAddr,
    input  logic [NREQ*DW-1:0] ReqData,
    output logic [NREQ-1:0]    Ack,
    input  logic               ClearReq,
    output logic               ClearBusy,
    output logic               ClearDone,
    output logic               WRF,
    output logic [AW-1:0]      WriteRegAddr,
    output logic [DW-1:0]      WriteRegData
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = AW + 1;
    // Sweep counter counts issued clear writes; reaching this value means the
    // write to the last address is on the port this cycle.
    localparam logic [CW-1:0] SWEEP_LEN = {1'b1, {AW{1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr,  w_ptr_nxt;
    logic [CW-1:0]   r_cnt,  w_cnt_nxt;
    logic [NREQ-1:0] r_ack,  w_ack_nxt;
    logic            r_wrf,  w_wrf_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [DW-1:0]   r_data, w_data_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;

    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_grant;
    logic            w_valid;
    logic [2:0]      w_win_idx;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_data;

    // A requester acked this cycle is still holding Req; mask it so it is not granted twice.
    assign w_eligible = Req & ~r_ack;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_valid    (w_valid)
    );

    assign w_win_idx = onehot_to_idx(8'(w_grant));

    // Select the winning requester's address and data.
    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win_addr = ReqAddr[i*AW +: AW];
                w_win_data = ReqData[i*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (Rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: a clear request wins in IDLE; the sweep ends once the last address has been issued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ClearReq) w_state_nxt = CLEAR;
            CLEAR:   if (r_cnt == SWEEP_LEN) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values: sweep write, arbitrated grant, or idle with address/data held.
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_cnt_nxt  = r_cnt;
        w_ack_nxt  = '0;
        w_wrf_nxt  = 1'b0;
        w_addr_nxt = r_addr;
        w_data_nxt = r_data;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (ClearReq) begin
                    w_wrf_nxt  = 1'b1;
                    w_addr_nxt = '0;
                    w_data_nxt = '0;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = CW'(1);
                end else if (w_valid) begin
                    w_ack_nxt  = w_grant;
                    w_wrf_nxt  = !((ZERO_PROTECT != 0) && (w_win_addr == '0));
                    w_addr_nxt = w_win_addr;
                    w_data_nxt = w_win_data;
                    w_ptr_nxt  = (int'(w_win_idx) == NREQ - 1) ? '0 : PW'(w_win_idx + 3'd1);
                end
            end
            CLEAR: begin
                if (r_cnt == SWEEP_LEN) begin
                    w_done_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_wrf_nxt  = 1'b1;
                    w_addr_nxt = r_cnt[AW-1:0];
                    w_data_nxt = '0;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset aborts any sweep or pending ack.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_ack  <= '0;
            r_wrf  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_ack  <= w_ack_nxt;
            r_wrf  <= w_wrf_nxt;
            r_addr <= w_addr_nxt;
            r_data <= w_data_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign Ack          = r_ack;
    assign WRF          = r_wrf;
    assign WriteRegAddr = r_addr;
    assign WriteRegData = r_data;
    assign ClearBusy    = r_busy;
    assign ClearDone    = r_done;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: two instances (ZERO_PROTECT 0 and 1) share the
// stimulus; a cycle model of the arbitration/clear rules is compared every
// negedge, and directed scenarios pin literal expectations.
module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic               Clk;
    logic               Rst;
    logic [NREQ-1:0]    Req;
    logic [NREQ*AW-1:0] ReqAddr;
    logic [NREQ*DW-1:0] ReqData;
    logic               ClearReq;

    logic [NREQ-1:0] a_ack,  z_ack;
    logic            a_busy, z_busy;
    logic            a_done, z_done;
    logic            a_wrf,  z_wrf;
    logic [AW-1:0]   a_addr, z_addr;
    logic [DW-1:0]   a_data, z_data;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_PROTECT(0)) u_dut_nz (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .Ack(a_ack), .ClearReq(ClearReq), .ClearBusy(a_busy), .ClearDone(a_done),
        .WRF(a_wrf), .WriteRegAddr(a_addr), .WriteRegData(a_data)
    );

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_PROTECT(1)) u_dut_zp (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .Ack(z_ack), .ClearReq(ClearReq), .ClearBusy(z_busy), .ClearDone(z_done),
        .WRF(z_wrf), .WriteRegAddr(z_addr), .WriteRegData(z_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register files attached to each write port.
    logic [DW-1:0] rf_nz [NREG];
    logic [DW-1:0] rf_zp [NREG];
    always @(posedge Clk) begin
        if (a_wrf) rf_nz[a_addr] <= a_data;
        if (z_wrf) rf_zp[z_addr] <= z_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_ptr;
    bit            m_clearing;
    int            m_age;        // cycles since the clear request was sampled
    bit [NREQ-1:0] m_ack;
    bit            m_wrf, m_wrf_zp;
    bit [AW-1:0]   m_addr;
    bit [DW-1:0]   m_data;
    bit            m_busy, m_done;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_ptr = 0; m_clearing = 0; m_age = 0; m_ack = '0;
            m_wrf = 0; m_wrf_zp = 0; m_addr = '0; m_data = '0;
            m_busy = 0; m_done = 0;
        end else begin
            bit [NREQ-1:0] prev_ack;
            int win;
            prev_ack = m_ack;
            m_ack = '0; m_wrf = 0; m_wrf_zp = 0; m_done = 0;
            if (m_clearing) begin
                m_age++;
                if (m_age <= NREG) begin
                    m_wrf = 1; m_wrf_zp = 1;
                    m_addr = AW'(m_age - 1); m_data = '0;
                end else begin
                    m_clearing = 0; m_busy = 0; m_done = 1;
                end
            end else if (ClearReq) begin
                m_clearing = 1; m_busy = 1; m_age = 1;
                m_wrf = 1; m_wrf_zp = 1; m_addr = '0; m_data = '0;
            end else begin
                win = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (win < 0 && Req[i] && !prev_ack[i]) win = i;
                end
                if (win >= 0) begin
                    m_ack[win] = 1'b1;
                    m_addr     = ReqAddr[win*AW +: AW];
                    m_data     = ReqData[win*DW +: DW];
                    m_wrf      = 1;
                    m_wrf_zp   = (m_addr != 0);
                    m_ptr      = (win + 1) % NREQ;
                end
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge Clk) begin
        if (cmp_en) begin
            check("cmp_ack_nz",  64'(a_ack),  64'(m_ack));
            check("cmp_ack_zp",  64'(z_ack),  64'(m_ack));
            check("cmp_wrf_nz",  64'(a_wrf),  64'(m_wrf));
            check("cmp_wrf_zp",  64'(z_wrf),  64'(m_wrf_zp));
            check("cmp_busy",    64'({a_busy, z_busy}), 64'({m_busy, m_busy}));
            check("cmp_done",    64'({a_done, z_done}), 64'({m_done, m_done}));
            if (m_wrf) begin
                check("cmp_addr_nz", 64'(a_addr), 64'(m_addr));
                check("cmp_addr_zp", 64'(z_addr), 64'(m_addr));
                check("cmp_data_nz", 64'(a_data), 64'(m_data));
                check("cmp_data_zp", 64'(z_data), 64'(m_data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        Req[idx]               = 1'b1;
        ReqAddr[idx*AW +: AW]  = addr;
        ReqData[idx*DW +: DW]  = data;
    endtask

    task automatic pulse_reset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int w;
        w = 0;
        while (!a_done && w < 40) begin
            tick();
            w++;
        end
        check(name, 64'(a_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz_count;
        Req = '0; ReqAddr = '0; ReqData = '0; ClearReq = 1'b0; Rst = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            rf_nz[r] = 32'hFFFF_0000 + r;
            rf_zp[r] = 32'hFFFF_0000 + r;
        end
        repeat (2) @(posedge Clk);
        #1;
        cmp_en = 1;
        check("reset_outputs_nz", 64'({a_ack, a_wrf, a_busy, a_done}), 64'd0);
        check("reset_addr_data", 64'({a_addr, a_data}), 64'd0);
        Rst = 1'b0;

        // Single write from requester 1.
        set_req(1, 5'd3, 32'hA5);
        tick();
        check("single_ack",  64'(a_ack),  64'b010);
        check("single_wrf",  64'(a_wrf),  64'd1);
        check("single_addr", 64'(a_addr), 64'd3);
        check("single_data", 64'(a_data), 64'hA5);
        Req[1] = 1'b0;
        tick();
        check("single_after", 64'({a_ack, a_wrf}), 64'd0);
        check("single_rf3", 64'(rf_nz[3]), 64'hA5);

        // Three-way contention, two rounds, from pointer 0.
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, AW'(5 + i), DW'(32'h100 * r + i + 1));
            for (int k = 0; k < NREQ; k++) begin
                tick();
                check("rr_order", 64'(a_ack), 64'(3'b001 << k));
                Req = Req & ~a_ack;
            end
        end
        tick();
        check("rr_idle", 64'(a_ack), 64'd0);
        check("rr_rf7", 64'(rf_nz[7]), 64'h103);

        // Requester 2 holds Req: acked on alternate cycles only.
        set_req(2, 5'd12, 32'hC0FFEE);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("hold_alt", 64'(a_ack), (i % 2 == 0) ? 64'b100 : 64'd0);
            if (i == 6) Req[2] = 1'b0;
        end
        tick();
        check("hold_end", 64'(a_ack), 64'd0);

        // Preload registers, then clear with requester 0 pending throughout.
        for (int a = 1; a < NREG; a++) begin
            set_req(1, AW'(a), 32'h1000 + a);
            tick();
            Req[1] = 1'b0;
            tick();
        end
        check("preload_rf31", 64'(rf_nz[31]), 64'h101F);
        ClearReq = 1'b1;
        set_req(0, 5'd9, 32'h99);
        tick();
        ClearReq = 1'b0;
        for (int k = 1; k <= NREG; k++) begin
            if (k > 1) tick();
            check("clear_addr", 64'(a_addr), 64'(k - 1));
            check("clear_busy_wrf_ack", 64'({a_busy, a_wrf, a_ack, a_data}), 64'({1'b1, 1'b1, 3'b000, 32'h0}));
        end
        tick();
        check("clear_done", 64'({a_done, a_busy, a_wrf, a_ack}), 64'({1'b1, 1'b0, 1'b0, 3'b000}));
        nz_count = 0;
        for (int r = 0; r < NREG; r++) begin
            if (rf_nz[r] != 0) nz_count++;
            if (rf_zp[r] != 0) nz_count++;
        end
        check("clear_rf_zero", 64'(nz_count), 64'd0);
        tick();
        check("post_clear_ack", 64'(a_ack), 64'b001);
        check("post_clear_write", 64'({a_wrf, a_addr, a_data}), 64'({1'b1, 5'd9, 32'h99}));
        Req[0] = 1'b0;
        tick();
        check("post_clear_idle", 64'({a_done, a_ack}), 64'd0);

        // Clear and request in the same cycle; request to address 0.
        ClearReq = 1'b1;
        set_req(0, 5'd0, 32'h55);
        tick();
        ClearReq = 1'b0;
        check("tie_clear_first", 64'({a_busy, a_ack}), 64'({1'b1, 3'b000}));
        wait_done("tie_done_seen");
        tick();
        check("zp_ack_nz", 64'(a_ack), 64'b001);
        check("zp_ack_zp", 64'(z_ack), 64'b001);
        check("zp_wrf", 64'({a_wrf, z_wrf}), 64'b10);
        Req[0] = 1'b0;
        tick();
        check("zp_rf0_nz", 64'(rf_nz[0]), 64'h55);
        check("zp_rf0_zp", 64'(rf_zp[0]), 64'h0);

        // Reset in the middle of a sweep.
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        begin
            int w;
            w = 0;
            while (!(a_busy && a_addr == 5'd10) && w < 40) begin
                tick();
                w++;
            end
        end
        check("sweep_reached_10", 64'({a_busy, a_addr}), 64'({1'b1, 5'd10}));
        Rst = 1'b1;
        #1;
        check("midrst_nz", 64'({a_ack, a_wrf, a_busy, a_done, a_addr}), 64'd0);
        check("midrst_zp", 64'({z_ack, z_wrf, z_busy, z_done, z_addr}), 64'd0);
        check("midrst_data", 64'({a_data, z_data}), 64'd0);
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_quiet", 64'({a_done, a_busy, a_wrf}), 64'd0);
        end
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        check("restart_sweep", 64'({a_busy, a_wrf, a_addr}), 64'({1'b1, 1'b1, 5'd0}));
        wait_done("restart_done_seen");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
